keypad_scanner: RTL and testbench

Scans a 4x4 active-low matrix keypad, debounces it, and encodes the held key as a 4-bit code with a level `pressed` flag. Sits directly upstream of the digit-entry counter: `enc_out`/`pressed` feed its `enc_in`/`pressed` inputs, so `pressed` is a clean level that stays high for the whole debounced hold.

---
 rtl/keypad_scanner.sv | 258 +++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad scanner with frame-based debounce and key encoding.
// Build option: KEYPAD_GHOST_REJECT_EN turns any multi-key frame into "no key".
`default_nettype none

module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic       clk,
  input  logic       off_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] enc_out,
  output logic       pressed,
  output logic       key_valid
);

  localparam int             SW        = $clog2(SCAN_DIV);
  localparam logic [SW-1:0]  SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0]  SLOT_ONE  = SW'(1);
  localparam logic [7:0]     DB_TARGET = 8'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAND = 2'd1,
    HELD = 2'd2,
    REL  = 2'd3
  } state_t;

  logic [1:0]    rst_ff;
  logic          rst_n;
  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic [SW-1:0] slot;
  logic [1:0]    col;
  logic [1:0]    col_nxt;
  logic          slot_last;
  logic          frame_end;
  logic [15:0]   hits;
  logic [15:0]   slot_hits;
  logic          scan_any;
  logic [3:0]    scan_code;
  logic          frame_done;
  logic          frame_hit;
  logic [3:0]    frame_code;

  state_t        state;
  state_t        state_n;
  logic [3:0]    cand;
  logic [3:0]    cand_n;
  logic [7:0]    cnt;
  logic [7:0]    cnt_n;
  logic [7:0]    cnt_inc;
  logic [3:0]    enc_n;
  logic          pressed_n;
  logic          key_valid_n;

  // Reset asserts immediately with off_n and releases on a clock edge.
  always_ff @(posedge clk or negedge off_n) begin
    if (!off_n) begin
      rst_ff <= 2'b00;
    end else begin
      rst_ff <= {rst_ff[0], 1'b1};
    end
  end

  assign rst_n = rst_ff[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
    end
  end

  assign slot_last = (slot == SLOT_LAST);
  assign frame_end = slot_last && (col == 2'd3);
  assign col_nxt   = col + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot    <= '0;
      col     <= 2'd0;
      col_out <= 4'b1110;
    end else if (slot_last) begin
      slot    <= '0;
      col     <= col_nxt;
      col_out <= ~(4'b0001 << col_nxt);
    end else begin
      slot    <= slot + SLOT_ONE;
    end
  end

  // Key index is 4*row + col; the current column's bits come from the live sample.
  always_comb begin
    slot_hits = hits;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (col == 2'(c)) begin
          slot_hits[4*r + c] = ~row_sync[r];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits <= '0;
    end else if (slot_last) begin
      hits <= frame_end ? 16'h0000 : slot_hits;
    end
  end

  function automatic logic [3:0] key_code(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = 4'hE;
      4'd13:   code = 4'h0;
      4'd14:   code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Walking down from index 15 lets the lowest active index overwrite the rest.
  always_comb begin
    scan_code = 4'hF;
    for (int i = 15; i >= 0; i--) begin
      if (slot_hits[i]) begin
        scan_code = key_code(4'(i));
      end
    end
`ifdef KEYPAD_GHOST_REJECT_EN
    scan_any = (|slot_hits) && ((slot_hits & (slot_hits - 16'd1)) == 16'h0000);
`else
    scan_any = |slot_hits;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      frame_hit  <= 1'b0;
      frame_code <= 4'hF;
    end else begin
      frame_done <= frame_end;
      if (frame_end) begin
        frame_hit  <= scan_any;
        frame_code <= scan_code;
      end
    end
  end

  assign cnt_inc = (cnt >= DB_TARGET) ? cnt : cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cand      <= 4'hF;
      cnt       <= 8'd0;
      enc_out   <= 4'hF;
      pressed   <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_n;
      cand      <= cand_n;
      cnt       <= cnt_n;
      enc_out   <= enc_n;
      pressed   <= pressed_n;
      key_valid <= key_valid_n;
    end
  end

  always_comb begin
    state_n     = state;
    cand_n      = cand;
    cnt_n       = cnt;
    enc_n       = enc_out;
    pressed_n   = pressed;
    key_valid_n = 1'b0;
    if (frame_done) begin
      case (state)
        IDLE: begin
          if (frame_hit) begin
            cand_n = frame_code;
            cnt_n  = 8'd1;
            if (DB_TARGET <= 8'd1) begin
              state_n     = HELD;
              enc_n       = frame_code;
              pressed_n   = 1'b1;
              key_valid_n = 1'b1;
            end else begin
              state_n = CAND;
            end
          end
        end
        CAND: begin
          if (!frame_hit) begin
            state_n = IDLE;
            cnt_n   = 8'd0;
          end else if (frame_code == cand) begin
            cnt_n = cnt_inc;
            if (cnt_inc >= DB_TARGET) begin
              state_n     = HELD;
              enc_n       = cand;
              pressed_n   = 1'b1;
              key_valid_n = 1'b1;
            end
          end else begin
            cand_n = frame_code;
            cnt_n  = 8'd1;
          end
        end
        HELD: begin
          if (!(frame_hit && (frame_code == enc_out))) begin
            cnt_n = 8'd1;
            if (DB_TARGET <= 8'd1) begin
              state_n   = IDLE;
              pressed_n = 1'b0;
            end else begin
              state_n = REL;
            end
          end
        end
        default: begin
          if (frame_hit && (frame_code == enc_out)) begin
            state_n = HELD;
          end else begin
            cnt_n = cnt_inc;
            if (cnt_inc >= DB_TARGET) begin
              state_n   = IDLE;
              pressed_n = 1'b0;
              cnt_n     = 8'd0;
            end
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed table-driven bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=3).
`default_nettype none

module tb_keypad_scanner;

  localparam logic [15:0] K_NONE = 16'h0000;
  localparam logic [15:0] K_1    = 16'h0001;
  localparam logic [15:0] K_2    = 16'h0002;
  localparam logic [15:0] K_5    = 16'h0020;
  localparam logic [15:0] K_7    = 16'h0100;
  localparam logic [15:0] K_E    = 16'h1000;
  localparam logic [15:0] K_HASH = 16'h4000;
  localparam logic [15:0] K_D    = 16'h8000;

  logic       clk;
  logic       off_n;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] enc_out;
  logic       pressed;
  logic       key_valid;
  logic [15:0] keys;

  int total;
  int passed;

  typedef struct {
    logic [15:0] keys;
    int          frames;
    logic        exp_pressed;
    logic [3:0]  exp_enc;
    int          exp_pulses;
  } vec_t;

  vec_t vecs[32];
  int   nvec;

  keypad_scanner #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CNT(3)
  ) dut (
    .clk      (clk),
    .off_n    (off_n),
    .row_in   (row_in),
    .col_out  (col_out),
    .enc_out  (enc_out),
    .pressed  (pressed),
    .key_valid(key_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Switch matrix: a closed key pulls its row low while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[4*r + c] && !col_out[c]) begin
          row_in[r] = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] k, input int f, input logic p, input logic [3:0] e, input int n);
    vecs[nvec].keys        = k;
    vecs[nvec].frames      = f;
    vecs[nvec].exp_pressed = p;
    vecs[nvec].exp_enc     = e;
    vecs[nvec].exp_pulses  = n;
    nvec++;
  endtask

  // Runs whole frames from one cycle past a frame boundary, counting key_valid pulses.
  task automatic run_frames(input int n, output int pulses);
    pulses = 0;
    repeat (16 * n) begin
      @(posedge clk);
      #1;
      if (key_valid) pulses++;
    end
  endtask

  // Leaves the bench 1 cycle after a frame boundary (just after the debounce update).
  task automatic align();
    logic [3:0] prev;
    bit         found;
    found = 1'b0;
    prev  = col_out;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      if (prev == 4'b0111 && col_out == 4'b1110) found = 1'b1;
      prev = col_out;
    end
    check("frame_align_found", {31'd0, found}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  pulses;
    bit  seen;

    total  = 0;
    passed = 0;
    nvec   = 0;
    keys   = K_NONE;
    off_n  = 1'b1;
    #3 off_n = 1'b0;
    #20 off_n = 1'b1;
    repeat (7) @(posedge clk);

    // Asynchronous reset in the middle of a scan.
    @(negedge clk);
    off_n = 1'b0;
    #1;
    check("rst_col_out",   {28'd0, col_out}, 32'hE);
    check("rst_enc_out",   {28'd0, enc_out}, 32'hF);
    check("rst_pressed",   {31'd0, pressed}, 32'd0);
    check("rst_key_valid", {31'd0, key_valid}, 32'd0);
    repeat (2) @(negedge clk);
    off_n = 1'b1;

    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (col_out != 4'b1110) seen = 1'b1;
    end
    check("col_step_1", {28'd0, col_out}, 32'hD);
    repeat (3) @(posedge clk);
    #1;
    check("col_hold_1", {28'd0, col_out}, 32'hD);
    @(posedge clk);
    #1;
    check("col_step_2", {28'd0, col_out}, 32'hB);
    repeat (4) @(posedge clk);
    #1;
    check("col_step_3", {28'd0, col_out}, 32'h7);
    repeat (4) @(posedge clk);
    #1;
    check("col_wrap", {28'd0, col_out}, 32'hE);

    add(K_NONE, 2, 1'b0, 4'hF, 0);
    add(K_5,    2, 1'b0, 4'hF, 0);
    add(K_5,    1, 1'b1, 4'h5, 1);
    add(K_5,    7, 1'b1, 4'h5, 0);
    add(K_NONE, 2, 1'b1, 4'h5, 0);
    add(K_NONE, 1, 1'b0, 4'h5, 0);
    add(K_7,    2, 1'b0, 4'h5, 0);
    add(K_NONE, 1, 1'b0, 4'h5, 0);
    add(K_7,    2, 1'b0, 4'h5, 0);
    add(K_7,    1, 1'b1, 4'h7, 1);
    add(K_7,    2, 1'b1, 4'h7, 0);
    add(K_NONE, 3, 1'b0, 4'h7, 0);
    add(K_E,    3, 1'b1, 4'hE, 1);
    add(K_NONE, 2, 1'b1, 4'hE, 0);
    add(K_E,    2, 1'b1, 4'hE, 0);
    add(K_NONE, 3, 1'b0, 4'hE, 0);
    add(K_1,    3, 1'b1, 4'h1, 1);
    add(K_2,    3, 1'b0, 4'h1, 0);
    add(K_2,    3, 1'b1, 4'h2, 1);
    add(K_NONE, 3, 1'b0, 4'h2, 0);
`ifdef KEYPAD_GHOST_REJECT_EN
    add(K_1 | K_D, 5, 1'b0, 4'h2, 0);
    add(K_NONE,    3, 1'b0, 4'h2, 0);
`else
    add(K_1 | K_D, 5, 1'b1, 4'h1, 1);
    add(K_NONE,    3, 1'b0, 4'h1, 0);
`endif
    add(K_HASH, 3, 1'b1, 4'hF, 1);
    add(K_NONE, 3, 1'b0, 4'hF, 0);

    align();
    for (int v = 0; v < nvec; v++) begin
      keys = vecs[v].keys;
      run_frames(vecs[v].frames, pulses);
      check($sformatf("vec%0d_pressed", v), {31'd0, pressed}, {31'd0, vecs[v].exp_pressed});
      check($sformatf("vec%0d_enc_out", v), {28'd0, enc_out}, {28'd0, vecs[v].exp_enc});
      check($sformatf("vec%0d_pulses", v),  pulses, vecs[v].exp_pulses);
    end

    // Reset during a hold drops pressed at once; the held key is debounced again.
    keys = K_5;
    run_frames(3, pulses);
    check("hold_pre_rst_pressed", {31'd0, pressed}, 32'd1);
    #2;
    off_n = 1'b0;
    #1;
    check("hold_rst_pressed", {31'd0, pressed}, 32'd0);
    check("hold_rst_enc_out", {28'd0, enc_out}, 32'hF);
    check("hold_rst_col_out", {28'd0, col_out}, 32'hE);
    @(negedge clk);
    off_n = 1'b1;
    align();
    check("rehold_frame1_pressed", {31'd0, pressed}, 32'd0);
    run_frames(1, pulses);
    check("rehold_frame2_pressed", {31'd0, pressed}, 32'd0);
    run_frames(1, pulses);
    check("rehold_frame3_pressed", {31'd0, pressed}, 32'd1);
    check("rehold_enc_out", {28'd0, enc_out}, 32'h5);
    check("rehold_pulses", pulses, 32'd1);
    keys = K_NONE;
    run_frames(3, pulses);
    check("final_release", {31'd0, pressed}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
